dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (EX_MEM address/write data/MemRead/MemWrite) and the slower backing data memory.
- Hits complete in the same cycle with no stall.
- Misses raise a stall that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB while the controller writes back a dirty victim and refills the line.
- The backing memory moves whole lines through a req/ack handshake.

---
 rtl/dcache_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_ctrl: direct-mapped write-back/write-allocate D-cache controller. |
// | Optional DCACHE_STATS_EN adds hit/miss counters.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module dcache_ctrl #(
  parameter int  INDEX_BITS  = 5,
  parameter int  OFFSET_BITS = 5,
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS,
  localparam int LINE_BITS   = 8 * (2 ** OFFSET_BITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int LINES     = 2 ** INDEX_BITS;
  localparam int WORD_BITS = OFFSET_BITS - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]  mem_wdata_q, mem_wdata_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;

  logic [TAG_BITS-1:0]   cpu_tag;
  logic [INDEX_BITS-1:0] cpu_idx;
  logic [WORD_BITS-1:0]  cpu_word;
  logic [1:0]            unused_addr_bits;

  logic hit;
  logic fill;

  assign cpu_tag          = cpu_addr_i[31:32-TAG_BITS];
  assign cpu_idx          = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign cpu_word         = cpu_addr_i[2 +: WORD_BITS];
  assign unused_addr_bits = cpu_addr_i[1:0];

  assign hit  = cpu_req_i & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag) & (state_q == IDLE);
  assign fill = (state_q == ALLOCATE) & mem_ack_i;

  assign cpu_stall_o = cpu_req_i & ~hit;
  assign cpu_rdata_o = hit ? data_q[cpu_idx][{cpu_word, 5'd0} +: 32] : 32'd0;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // The request registers are loaded once per phase so the memory sees stable
  // address/data for the whole handshake, independent of the CPU inputs.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          miss_tag_d = cpu_tag;
          miss_idx_d = cpu_idx;
          mem_req_d  = 1'b1;
          if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
            state_d     = WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[cpu_idx], cpu_idx, {OFFSET_BITS{1'b0}}};
            mem_wdata_d = data_q[cpu_idx];
          end else begin
            state_d     = ALLOCATE;
            mem_we_d    = 1'b0;
            mem_addr_d  = {cpu_tag, cpu_idx, {OFFSET_BITS{1'b0}}};
            mem_wdata_d = '0;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = ALLOCATE;
          mem_we_d    = 1'b0;
          mem_addr_d  = {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
          mem_wdata_d = '0;
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      miss_tag_q  <= miss_tag_d;
      miss_idx_q  <= miss_idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[miss_idx_q] <= 1'b1;
      dirty_q[miss_idx_q] <= 1'b0;
    end else if (hit && cpu_we_i) begin
      dirty_q[cpu_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; a reset only blocks their update.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill) begin
        tag_q[miss_idx_q]  <= miss_tag_q;
        data_q[miss_idx_q] <= mem_rdata_i;
      end else if (hit && cpu_we_i) begin
        data_q[cpu_idx][{cpu_word, 5'd0} +: 32] <= cpu_wdata_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        fill_done_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The hit that retires a miss is already counted as that miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_done_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      fill_done_q <= fill;
      if (hit && !fill_done_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && cpu_req_i && !hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dcache_ctrl: directed + random bench for dcache_ctrl, line-level model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dcache_ctrl;

  localparam int LB = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_we_i;
  logic [31:0]   cpu_addr_i, cpu_wdata_i;
  logic [31:0]   cpu_rdata_o;
  logic          cpu_stall_o;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [LB-1:0] mem_wdata_o;
  logic [LB-1:0] mem_rdata_i;
  logic          mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int n_hits = 0;
  int n_miss = 0;

  // Reference model: backing memory and cache contents keyed by line address / set.
  logic [LB-1:0] mem   [logic [31:0]];
  logic [31:0]   m_la  [int];
  bit            m_dirty [int];
  logic [LB-1:0] m_dat [int];

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [LB-1:0] l, input int w);
    return l[w*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle();
    cpu_req_i  = 1'b0;
    cpu_we_i   = $urandom_range(0, 1) == 1;
    cpu_addr_i = $urandom;
    @(negedge clk_i);
    chk("idle_stall", cpu_stall_o, 1'b0);
    chk("idle_rdata", cpu_rdata_o, 32'd0);
    chk("idle_memreq", mem_req_o, 1'b0);
    tick();
  endtask

  // One CPU access; memory acks after dwb / dfe extra cycles of each request.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int dwb, input int dfe);
    int            idx, w, stalls, pen;
    logic [31:0]   la, vla;
    bit            hit_e, dirty_e;
    logic [LB-1:0] tmp;
    idx     = int'(addr[9:5]);
    w       = int'(addr[4:2]);
    la      = {addr[31:5], 5'd0};
    hit_e   = m_la.exists(idx) && (m_la[idx] == la);
    dirty_e = !hit_e && m_la.exists(idx) && m_dirty[idx];
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    @(negedge clk_i);
    chk("stall0", cpu_stall_o, !hit_e);
    if (hit_e) begin
      n_hits++;
      if (!we) chk("rd_hit", cpu_rdata_o, word_of(m_dat[idx], w));
      chk("hit_memreq", mem_req_o, 1'b0);
    end else begin
      n_miss++;
      chk("miss_rdata0", cpu_rdata_o, 32'd0);
      chk("miss_memreq0", mem_req_o, 1'b0);
      chk("miss_memaddr0", mem_addr_o, 32'd0);
      stalls = 1;
      pen    = 1 + (dirty_e ? dwb + 1 : 0) + dfe + 1;
      tick();
      if (dirty_e) begin
        vla = m_la[idx];
        for (int c = 0; c <= dwb; c++) begin
          @(negedge clk_i);
          stalls += int'(cpu_stall_o);
          chk("wb_req", mem_req_o, 1'b1);
          chk("wb_we", mem_we_o, 1'b1);
          chk("wb_addr", mem_addr_o, vla);
          chk("wb_data", mem_wdata_o, m_dat[idx]);
          mem_ack_i = (c == dwb);
          tick();
          mem_ack_i = 1'b0;
        end
        mem[vla] = m_dat[idx];
      end
      for (int c = 0; c <= dfe; c++) begin
        @(negedge clk_i);
        stalls += int'(cpu_stall_o);
        chk("fe_req", mem_req_o, 1'b1);
        chk("fe_we", mem_we_o, 1'b0);
        chk("fe_addr", mem_addr_o, la);
        if (c == dfe) begin
          if (!mem.exists(la)) mem[la] = rand_line();
          mem_rdata_i = mem[la];
          mem_ack_i   = 1'b1;
        end
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = rand_line();
      end
      m_la[idx]    = la;
      m_dat[idx]   = mem[la];
      m_dirty[idx] = 1'b0;
      @(negedge clk_i);
      chk("done_stall", cpu_stall_o, 1'b0);
      chk("done_memreq", mem_req_o, 1'b0);
      chk("penalty", stalls, pen);
      if (!we) chk("rd_fill", cpu_rdata_o, word_of(m_dat[idx], w));
    end
    if (we) begin
      tmp = m_dat[idx];
      tmp[w*32 +: 32] = wd;
      m_dat[idx]   = tmp;
      m_dirty[idx] = 1'b1;
    end
    tick();
  endtask

  initial begin
    logic [LB-1:0] l;
    logic [31:0]   a;
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_memreq", mem_req_o, 1'b0);
    chk("rst_memwe", mem_we_o, 1'b0);
    chk("rst_memaddr", mem_addr_o, 32'd0);
    chk("rst_memwdata", mem_wdata_o, '0);
    chk("rst_rdata", cpu_rdata_o, 32'd0);
    tick();

    // Cold load with 3-cycle ack delay, then same-line hit on word 2.
    l = rand_line();
    l[2*32 +: 32] = 32'hDEADBEEF;
    mem[32'h40] = l;
    access(1'b0, 32'h0000_0040, 32'd0, 0, 3);
    access(1'b0, 32'h0000_0048, 32'd0, 0, 0);
    chk("word2", word_of(m_dat[2], 2), 32'hDEADBEEF);

    // Dirty conflict: writeback of 0x40 then fetch 0x440.
    access(1'b1, 32'h0000_0040, 32'h12345678, 0, 0);
    access(1'b0, 32'h0000_0440, 32'd0, 2, 1);
    chk("wb_word0", word_of(mem[32'h40], 0), 32'h12345678);

    // Store miss to an invalid line, later evicted by a conflict.
    access(1'b1, 32'h0000_0084, 32'hCAFEF00D, 1, 0);
    access(1'b0, 32'h0000_0480, 32'd0, 1, 2);
    chk("wb80_word1", word_of(mem[32'h80], 1), 32'hCAFEF00D);

    // Reset in the middle of a writeback abandons it.
    access(1'b1, 32'h0000_0440, 32'hA5A5A5A5, 0, 0);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0040;
    @(negedge clk_i);
    chk("rwb_stall", cpu_stall_o, 1'b1);
    tick();
    @(negedge clk_i);
    chk("rwb_req", mem_req_o, 1'b1);
    chk("rwb_we", mem_we_o, 1'b1);
    chk("rwb_addr", mem_addr_o, 32'h0000_0440);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rwb_req_drop", mem_req_o, 1'b0);
    chk("rwb_addr_clr", mem_addr_o, 32'd0);
    tick();
    m_la.delete();
    m_dirty.delete();
    n_hits = 0;
    n_miss = 0;
    access(1'b0, 32'h0000_0040, 32'd0, 2, 0);

`ifdef DCACHE_STATS_EN
    // Stats sequence starts from a clean reset.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_la.delete();
    m_dirty.delete();
    n_hits = 0;
    n_miss = 0;
    access(1'b0, 32'h0000_0100, 32'd0, 0, 1);
    access(1'b0, 32'h0000_0104, 32'd0, 0, 0);
    access(1'b1, 32'h0000_0108, 32'h1, 0, 0);
    access(1'b0, 32'h0000_0100, 32'd0, 0, 0);
    @(negedge clk_i);
    chk("miss_cnt_plan", miss_cnt_o, 32'd1);
    chk("hit_cnt_plan", hit_cnt_o, 32'd3);
    tick();
`endif

    // Random traffic over 4 tags x 4 sets to force frequent conflicts.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access($urandom_range(0, 1) == 1, a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk_i);
    chk("miss_cnt", miss_cnt_o, n_miss);
    chk("hit_cnt", hit_cnt_o, n_hits);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
